// File: rtl/lut_load_sequencer.sv
// Serialises lookup-table entries onto a GPIO write bus (addr, data, w_clk strobe)
// and pauses the sample path while a load burst is in progress.
module lut_load_sequencer #(
  parameter int NUM_BITS   = 8,
  parameter int SETUP_CYC  = 2,
  parameter int STROBE_CYC = 1,
  parameter int HOLD_CYC   = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [15:0]         ld_addr,
  input  logic [7:0]          ld_data,
  input  logic                ld_last,
  input  logic                ld_valid,
  output logic                ld_ready,
  output logic [31:0]         gpio_out,
  input  logic [NUM_BITS-1:0] smp_in,
  input  logic                smp_in_valid,
  output logic [NUM_BITS-1:0] smp_out,
  output logic                smp_out_valid,
  output logic                loading,
  output logic                load_done,
  output logic [15:0]         drop_cnt
);

  typedef enum logic [2:0] {IDLE, SETUP, STROBE, HOLD, DONE} state_t;

  localparam logic [3:0] SETUP_END  = 4'(SETUP_CYC - 1);
  localparam logic [3:0] STROBE_END = 4'(STROBE_CYC - 1);
  localparam logic [3:0] HOLD_END   = 4'(HOLD_CYC - 1);

  state_t              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic [15:0]         addr_q, addr_d;
  logic [7:0]          data_q, data_d;
  logic                last_q, last_d;
  logic                wclk_q, wclk_d;
  logic                loading_q, loading_d;
  logic [NUM_BITS-1:0] smp_out_q, smp_out_d;
  logic                smp_out_valid_q, smp_out_valid_d;
  logic [15:0]         drop_cnt_q, drop_cnt_d;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    data_d    = data_q;
    last_d    = last_q;
    loading_d = loading_q;
    case (state_q)
      IDLE: begin
        if (ld_valid) begin
          addr_d    = ld_addr;
          data_d    = ld_data;
          last_d    = ld_last;
          loading_d = 1'b1;
          cnt_d     = 4'd0;
          state_d   = SETUP;
        end
      end
      SETUP: begin
        if (cnt_q == SETUP_END) begin
          cnt_d   = 4'd0;
          state_d = STROBE;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      STROBE: begin
        if (cnt_q == STROBE_END) begin
          cnt_d   = 4'd0;
          state_d = HOLD;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      HOLD: begin
        if (cnt_q == HOLD_END) begin
          cnt_d   = 4'd0;
          state_d = last_q ? DONE : IDLE;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      DONE: begin
        loading_d = 1'b0;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // w_clk is registered against the next state so the strobe lines up with STROBE
    wclk_d = (state_d == STROBE);
  end

  always_comb begin
    smp_out_d       = smp_out_q;
    smp_out_valid_d = 1'b0;
    drop_cnt_d      = drop_cnt_q;
    if (!loading_q) begin
      smp_out_d       = smp_in;
      smp_out_valid_d = smp_in_valid;
    end else if (smp_in_valid && (drop_cnt_q != 16'hFFFF)) begin
      drop_cnt_d = drop_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q         <= IDLE;
      cnt_q           <= 4'd0;
      addr_q          <= 16'd0;
      data_q          <= 8'd0;
      last_q          <= 1'b0;
      wclk_q          <= 1'b0;
      loading_q       <= 1'b0;
      smp_out_q       <= '0;
      smp_out_valid_q <= 1'b0;
      drop_cnt_q      <= 16'd0;
    end else begin
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      addr_q          <= addr_d;
      data_q          <= data_d;
      last_q          <= last_d;
      wclk_q          <= wclk_d;
      loading_q       <= loading_d;
      smp_out_q       <= smp_out_d;
      smp_out_valid_q <= smp_out_valid_d;
      drop_cnt_q      <= drop_cnt_d;
    end
  end

  assign ld_ready      = (state_q == IDLE) && rst;
  assign gpio_out      = {7'd0, wclk_q, data_q, addr_q};
  assign smp_out       = smp_out_q;
  assign smp_out_valid = smp_out_valid_q;
  assign loading       = loading_q;
  assign load_done     = (state_q == DONE);
  assign drop_cnt      = drop_cnt_q;

endmodule

// File: tb/tb_lut_load_sequencer.sv
// Directed bench for lut_load_sequencer: a vector table for the single-entry load
// and pass-through, plus hand sequences for bursts, reset mid-strobe and saturation.
module tb_lut_load_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] ld_addr;
  logic [7:0]  ld_data;
  logic        ld_last;
  logic        ld_valid;
  logic        ld_ready;
  logic [31:0] gpio_out;
  logic [7:0]  smp_in;
  logic        smp_in_valid;
  logic [7:0]  smp_out;
  logic        smp_out_valid;
  logic        loading;
  logic        load_done;
  logic [15:0] drop_cnt;

  int checks = 0;
  int errors = 0;

  lut_load_sequencer #(
    .NUM_BITS(8), .SETUP_CYC(2), .STROBE_CYC(1), .HOLD_CYC(2)
  ) dut (
    .clk(clk), .rst(rst),
    .ld_addr(ld_addr), .ld_data(ld_data), .ld_last(ld_last),
    .ld_valid(ld_valid), .ld_ready(ld_ready),
    .gpio_out(gpio_out),
    .smp_in(smp_in), .smp_in_valid(smp_in_valid),
    .smp_out(smp_out), .smp_out_valid(smp_out_valid),
    .loading(loading), .load_done(load_done), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic [15:0] addr;
    logic [7:0]  data;
    logic        last;
    logic        valid;
    logic [7:0]  smp;
    logic        smp_v;
    logic [31:0] e_gpio;
    logic        e_ready;
    logic        e_loading;
    logic        e_done;
    logic [7:0]  e_smp;
    logic        e_smp_v;
    logic [15:0] e_drop;
  } vec_t;

  vec_t vecs[13];

  function automatic vec_t mk(logic r, logic [15:0] a, logic [7:0] d, logic l, logic v,
                              logic [7:0] s, logic sv, logic [31:0] eg, logic er,
                              logic el, logic ed, logic [7:0] es, logic esv,
                              logic [15:0] edr);
    vec_t t;
    t.rst = r; t.addr = a; t.data = d; t.last = l; t.valid = v;
    t.smp = s; t.smp_v = sv;
    t.e_gpio = eg; t.e_ready = er; t.e_loading = el; t.e_done = ed;
    t.e_smp = es; t.e_smp_v = esv; t.e_drop = edr;
    return t;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic checkValue(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    rst          = v.rst;
    ld_addr      = v.addr;
    ld_data      = v.data;
    ld_last      = v.last;
    ld_valid     = v.valid;
    smp_in       = v.smp;
    smp_in_valid = v.smp_v;
  endtask

  task automatic checkOutput(input int idx, input vec_t v);
    checkValue($sformatf("vec%0d gpio_out", idx), gpio_out, v.e_gpio);
    checkValue($sformatf("vec%0d ld_ready", idx), 32'(ld_ready), 32'(v.e_ready));
    checkValue($sformatf("vec%0d loading", idx), 32'(loading), 32'(v.e_loading));
    checkValue($sformatf("vec%0d load_done", idx), 32'(load_done), 32'(v.e_done));
    checkValue($sformatf("vec%0d smp_out", idx), 32'(smp_out), 32'(v.e_smp));
    checkValue($sformatf("vec%0d smp_out_valid", idx), 32'(smp_out_valid), 32'(v.e_smp_v));
    checkValue($sformatf("vec%0d drop_cnt", idx), 32'(drop_cnt), 32'(v.e_drop));
  endtask

  initial begin
    int idx;
    int pulses;
    int dones;
    int lo_err;
    logic prev_w;
    logic hs_seen;

    rst = 1'b0; ld_addr = '0; ld_data = '0; ld_last = 1'b0; ld_valid = 1'b0;
    smp_in = '0; smp_in_valid = 1'b0;

    //          rst addr      data   lst vld smp    sv | gpio          rdy lo dn smp   sv drop
    vecs[0]  = mk(0, 16'h0000, 8'h00, 0, 0, 8'h00, 0, 32'h00000000, 0, 0, 0, 8'h00, 0, 16'd0);
    vecs[1]  = mk(1, 16'h0000, 8'h00, 0, 0, 8'h00, 0, 32'h00000000, 1, 0, 0, 8'h00, 0, 16'd0);
    vecs[2]  = mk(1, 16'h0000, 8'h00, 0, 0, 8'h3C, 1, 32'h00000000, 1, 0, 0, 8'h3C, 1, 16'd0);
    vecs[3]  = mk(1, 16'h0000, 8'h00, 0, 0, 8'h11, 0, 32'h00000000, 1, 0, 0, 8'h11, 0, 16'd0);
    vecs[4]  = mk(1, 16'h0012, 8'hA5, 1, 1, 8'h55, 1, 32'h00A50012, 0, 1, 0, 8'h55, 1, 16'd0);
    vecs[5]  = mk(1, 16'h0000, 8'h00, 0, 0, 8'h77, 1, 32'h00A50012, 0, 1, 0, 8'h55, 0, 16'd1);
    vecs[6]  = mk(1, 16'hFFFF, 8'hFF, 0, 1, 8'h77, 1, 32'h01A50012, 0, 1, 0, 8'h55, 0, 16'd2);
    vecs[7]  = mk(1, 16'hFFFF, 8'hFF, 0, 1, 8'h77, 1, 32'h00A50012, 0, 1, 0, 8'h55, 0, 16'd3);
    vecs[8]  = mk(1, 16'h0000, 8'h00, 0, 0, 8'h77, 1, 32'h00A50012, 0, 1, 0, 8'h55, 0, 16'd4);
    vecs[9]  = mk(1, 16'h0000, 8'h00, 0, 0, 8'h77, 1, 32'h00A50012, 0, 1, 1, 8'h55, 0, 16'd5);
    vecs[10] = mk(1, 16'h0000, 8'h00, 0, 0, 8'h77, 1, 32'h00A50012, 1, 0, 0, 8'h55, 0, 16'd6);
    vecs[11] = mk(1, 16'h0000, 8'h00, 0, 0, 8'h77, 1, 32'h00A50012, 1, 0, 0, 8'h77, 1, 16'd6);
    vecs[12] = mk(1, 16'h0000, 8'h00, 0, 0, 8'h77, 0, 32'h00A50012, 1, 0, 0, 8'h77, 0, 16'd6);

    step();
    for (int i = 0; i < 13; i++) begin
      applyStimulus(vecs[i]);
      step();
      checkOutput(i, vecs[i]);
    end

    // Three-entry burst: loading must stay high between entries, one done pulse total
    ld_valid = 1'b0; smp_in_valid = 1'b0;
    idx = 0; pulses = 0; dones = 0; lo_err = 0; prev_w = 1'b0; hs_seen = 1'b0;
    for (int cyc = 0; cyc < 60 && dones == 0; cyc++) begin
      if (ld_ready && idx < 3) begin
        ld_valid = 1'b1;
        ld_addr  = 16'(idx);
        ld_data  = 8'(8'h10 + idx);
        ld_last  = (idx == 2);
        idx++;
        hs_seen  = 1'b1;
      end else begin
        ld_valid = 1'b0;
      end
      step();
      if (gpio_out[24] && !prev_w) pulses++;
      prev_w = gpio_out[24];
      if (hs_seen && !loading) lo_err++;
      if (load_done) dones++;
    end
    ld_valid = 1'b0;
    checkValue("burst entries", 32'(idx), 32'd3);
    checkValue("burst w_clk pulses", 32'(pulses), 32'd3);
    checkValue("burst load_done pulses", 32'(dones), 32'd1);
    checkValue("burst loading gaps", 32'(lo_err), 32'd0);
    checkValue("burst gpio in DONE", gpio_out, 32'h00120002);
    step();
    checkValue("burst loading after DONE", 32'(loading), 32'd0);
    checkValue("burst load_done after DONE", 32'(load_done), 32'd0);
    checkValue("burst ld_ready after DONE", 32'(ld_ready), 32'd1);

    // Reset while w_clk is high abandons the burst
    ld_valid = 1'b1; ld_addr = 16'hBEEF; ld_data = 8'h5A; ld_last = 1'b1;
    smp_in_valid = 1'b1; smp_in = 8'h42;
    step();
    ld_valid = 1'b0;
    for (int i = 0; i < 20 && !gpio_out[24]; i++) step();
    checkValue("strobe reached", 32'(gpio_out[24]), 32'd1);
    checkValue("drops before reset nonzero", 32'(drop_cnt != 16'd0), 32'd1);
    rst = 1'b0;
    step();
    checkValue("rst gpio_out", gpio_out, 32'h0);
    checkValue("rst loading", 32'(loading), 32'd0);
    checkValue("rst drop_cnt", 32'(drop_cnt), 32'd0);
    checkValue("rst load_done", 32'(load_done), 32'd0);
    checkValue("rst smp_out_valid", 32'(smp_out_valid), 32'd0);
    checkValue("rst smp_out", 32'(smp_out), 32'd0);
    checkValue("rst ld_ready", 32'(ld_ready), 32'd0);
    rst = 1'b1; smp_in_valid = 1'b0;
    step();
    checkValue("post-rst ld_ready", 32'(ld_ready), 32'd1);
    dones = 0; pulses = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (load_done) dones++;
      if (gpio_out[24]) pulses++;
    end
    checkValue("post-rst load_done pulses", 32'(dones), 32'd0);
    checkValue("post-rst w_clk highs", 32'(pulses), 32'd0);

    // Saturation of the drop counter
    dut.drop_cnt_q = 16'hFFFE;
    #1;
    ld_valid = 1'b1; ld_addr = 16'h0001; ld_data = 8'h01; ld_last = 1'b1;
    step();
    ld_valid = 1'b0;
    checkValue("sat hold when idle", 32'(drop_cnt), 32'h0000FFFE);
    smp_in_valid = 1'b1;
    for (int i = 0; i < 3; i++) step();
    checkValue("sat after 3 drops", 32'(drop_cnt), 32'h0000FFFF);
    for (int i = 0; i < 20 && !ld_ready; i++) step();
    checkValue("sat ld_ready back", 32'(ld_ready), 32'd1);
    checkValue("sat stays", 32'(drop_cnt), 32'h0000FFFF);
    smp_in_valid = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
